// File: rtl/addsub_serial.sv
// addsub_serial: multi-cycle two's complement adder/subtracter.
// Walks a WIDTH-bit operand pair CHUNK bits per cycle, LSB chunk first,
// and keeps the ripple carry in a register between cycles. A valid/ready
// handshake is used on both sides. The result is reported with carry,
// signed-overflow and zero flags.
module addsub_serial #(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] data_operandA,
  input  logic [WIDTH-1:0] data_operandB,
  input  logic [4:0]       ctrl_ALUopcode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] data_result,
  output logic             carry_out,
  output logic             overflow,
  output logic             zero
);

  localparam int N  = WIDTH / CHUNK;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam int BW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  // Reject a chunk size that does not tile the operand exactly.
  generate
    if ((CHUNK < 1) || (CHUNK > WIDTH) || ((WIDTH % CHUNK) != 0)) begin : g_bad_cfg
      $error("addsub_serial: WIDTH must be a positive multiple of CHUNK");
    end
  endgenerate

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  // Captured request. b holds the operand already inverted for subtraction.
  typedef struct packed {
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
  } opnd_t;

  state_t          state_q;
  opnd_t           op_q;
  logic            cy_q;
  logic [CW-1:0]   cnt_q;

  logic [BW-1:0]    base;
  logic [CHUNK-1:0] a_chk;
  logic [CHUNK-1:0] b_chk;
  logic [CHUNK-1:0] s_chk;
  logic             c_chk;
  logic             last;
  logic             ovf_next;
  logic [WIDTH-1:0] res_next;

  // Opcode bits [4:1] carry no meaning for this block.
  logic unused_opc;
  assign unused_opc = ^ctrl_ALUopcode[4:1];

  // One chunk of the ripple add, plus the result with this chunk merged in.
  always_comb begin
    base     = BW'(int'(cnt_q) * CHUNK);
    a_chk    = op_q.a[base +: CHUNK];
    b_chk    = op_q.b[base +: CHUNK];
    {c_chk, s_chk} = {1'b0, a_chk} + {1'b0, b_chk} + (CHUNK+1)'(cy_q);
    res_next = data_result;
    res_next[base +: CHUNK] = s_chk;
    last     = (cnt_q == CW'(N - 1));
    // Same-sign inputs with a differently-signed result overflowed.
    ovf_next = (op_q.a[WIDTH-1] == op_q.b[WIDTH-1]) &&
               (s_chk[CHUNK-1] != op_q.a[WIDTH-1]);
  end

  // Control FSM. All outputs are registered here.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= IDLE;
      op_q        <= '0;
      cy_q        <= 1'b0;
      cnt_q       <= '0;
      in_ready    <= 1'b1;
      out_valid   <= 1'b0;
      data_result <= '0;
      carry_out   <= 1'b0;
      overflow    <= 1'b0;
      zero        <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid && in_ready) begin
            // Subtraction is A + ~B + 1, so the +1 enters as the first carry.
            op_q.a   <= data_operandA;
            op_q.b   <= ctrl_ALUopcode[0] ? ~data_operandB : data_operandB;
            cy_q     <= ctrl_ALUopcode[0];
            cnt_q    <= '0;
            in_ready <= 1'b0;
            state_q  <= RUN;
          end
        end
        RUN: begin
          data_result <= res_next;
          cy_q        <= c_chk;
          cnt_q       <= cnt_q + CW'(1);
          if (last) begin
            carry_out <= c_chk;
            overflow  <= ovf_next;
            zero      <= (res_next == '0);
            out_valid <= 1'b1;
            cnt_q     <= '0;
            state_q   <= DONE;
          end
        end
        DONE: begin
          // Hold the result until the consumer takes it.
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state_q   <= IDLE;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_addsub_serial.sv
// Bench for addsub_serial: three configurations (32/8, 8/1, 64/64) share
// one clock and reset. Directed cases on the 32/8 instance, randomized
// add/sub against an arithmetic reference model on the other two.
module tb_addsub_serial;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset;
  logic       in_valid [3];
  logic       out_ready[3];
  logic [63:0] opa[3];
  logic [63:0] opb[3];
  logic [4:0]  opc[3];

  logic        in_rdy [3];
  logic        out_vld[3];
  logic        cout_o [3];
  logic        ovf_o  [3];
  logic        zero_o [3];
  logic [63:0] res_o  [3];

  logic ir0, ov0, c0, o0, z0;  logic [31:0] r0;
  logic ir1, ov1, c1, o1, z1;  logic [7:0]  r1;
  logic ir2, ov2, c2, o2, z2;  logic [63:0] r2;

  addsub_serial #(.WIDTH(32), .CHUNK(8)) u_dut0 (
    .clock(clk), .reset(reset), .in_valid(in_valid[0]), .in_ready(ir0),
    .data_operandA(opa[0][31:0]), .data_operandB(opb[0][31:0]),
    .ctrl_ALUopcode(opc[0]), .out_valid(ov0), .out_ready(out_ready[0]),
    .data_result(r0), .carry_out(c0), .overflow(o0), .zero(z0));

  addsub_serial #(.WIDTH(8), .CHUNK(1)) u_dut1 (
    .clock(clk), .reset(reset), .in_valid(in_valid[1]), .in_ready(ir1),
    .data_operandA(opa[1][7:0]), .data_operandB(opb[1][7:0]),
    .ctrl_ALUopcode(opc[1]), .out_valid(ov1), .out_ready(out_ready[1]),
    .data_result(r1), .carry_out(c1), .overflow(o1), .zero(z1));

  addsub_serial #(.WIDTH(64), .CHUNK(64)) u_dut2 (
    .clock(clk), .reset(reset), .in_valid(in_valid[2]), .in_ready(ir2),
    .data_operandA(opa[2]), .data_operandB(opb[2]),
    .ctrl_ALUopcode(opc[2]), .out_valid(ov2), .out_ready(out_ready[2]),
    .data_result(r2), .carry_out(c2), .overflow(o2), .zero(z2));

  // Gather per-instance outputs into indexable arrays.
  always_comb begin
    in_rdy[0] = ir0; out_vld[0] = ov0; cout_o[0] = c0; ovf_o[0] = o0; zero_o[0] = z0; res_o[0] = 64'(r0);
    in_rdy[1] = ir1; out_vld[1] = ov1; cout_o[1] = c1; ovf_o[1] = o1; zero_o[1] = z1; res_o[1] = 64'(r1);
    in_rdy[2] = ir2; out_vld[2] = ov2; cout_o[2] = c2; ovf_o[2] = o2; zero_o[2] = z2; res_o[2] = r2;
  end

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic int wof(input int s);
    return (s == 0) ? 32 : (s == 1) ? 8 : 64;
  endfunction

  function automatic int nof(input int s);
    return (s == 0) ? 4 : (s == 1) ? 8 : 1;
  endfunction

  function automatic logic [63:0] mask_of(input int w);
    return (w == 64) ? '1 : ((64'd1 << w) - 64'd1);
  endfunction

  // Reference: plain unsigned/signed integer arithmetic on w-bit values.
  task automatic model(input int w, input logic [63:0] a_in, input logic [63:0] b_in,
                       input logic sub, output logic [63:0] r, output logic c,
                       output logic o, output logic z);
    logic [63:0]        a, b, m;
    logic [66:0]        u;
    logic signed [66:0] sa, sb, sr, pw;
    m  = mask_of(w);
    a  = a_in & m;
    b  = b_in & m;
    pw = 67'sd1 <<< w;
    sa = $signed({3'b0, a});
    sb = $signed({3'b0, b});
    if (a[w-1]) sa = sa - pw;
    if (b[w-1]) sb = sb - pw;
    if (sub) begin
      r  = (a - b) & m;
      c  = (a >= b);
      sr = sa - sb;
    end else begin
      u  = {3'b0, a} + {3'b0, b};
      r  = u[63:0] & m;
      c  = u[w];
      sr = sa + sb;
    end
    o = (sr >= (pw / 2)) || (sr < -(pw / 2));
    z = (r == 64'd0);
  endtask

  // Issue one op on instance s and collect its result. hold delays
  // out_ready for that many cycles; poke drives in_valid while held.
  task automatic do_op(input int s, input logic [63:0] a, input logic [63:0] b,
                       input logic [4:0] op, input int hold, input bit poke,
                       output logic [63:0] r, output logic c, output logic o,
                       output logic z);
    int lat;
    @(negedge clk);
    chk("in_ready before accept", 64'(in_rdy[s]), 64'd1);
    out_ready[s] = (hold == 0);
    in_valid[s]  = 1'b1;
    opa[s] = a; opb[s] = b; opc[s] = op;
    @(posedge clk);
    @(negedge clk);
    // Scramble inputs after the accept edge; they must be ignored.
    in_valid[s] = 1'b0;
    opa[s] = {$urandom, $urandom}; opb[s] = {$urandom, $urandom}; opc[s] = 5'($urandom);
    lat = 0;
    while (!out_vld[s] && lat < 300) begin
      @(posedge clk);
      @(negedge clk);
      lat++;
    end
    // out_valid first shows up after N edges following the accept edge.
    chk("latency", 64'(lat), 64'(nof(s)));
    r = res_o[s]; c = cout_o[s]; o = ovf_o[s]; z = zero_o[s];
    for (int i = 0; i < hold; i++) begin
      if (poke) begin
        in_valid[s] = 1'b1;
        opa[s] = {$urandom, $urandom}; opb[s] = {$urandom, $urandom}; opc[s] = 5'($urandom);
      end
      @(posedge clk);
      @(negedge clk);
      chk("held out_valid", 64'(out_vld[s]), 64'd1);
      chk("held in_ready", 64'(in_rdy[s]), 64'd0);
      chk("held result", res_o[s], r);
      chk("held flags", {61'd0, cout_o[s], ovf_o[s], zero_o[s]}, {61'd0, c, o, z});
    end
    in_valid[s]  = 1'b0;
    out_ready[s] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("idle in_ready", 64'(in_rdy[s]), 64'd1);
    chk("idle out_valid", 64'(out_vld[s]), 64'd0);
    chk("idle result kept", res_o[s], r);
  endtask

  function automatic logic [63:0] rnd_opnd(input int w);
    int mode;
    mode = $urandom_range(0, 7);
    case (mode)
      0: return 64'd0;
      1: return mask_of(w);
      2: return 64'd1 << (w - 1);
      3: return mask_of(w) >> 1;
      default: return {$urandom, $urandom} & mask_of(w);
    endcase
  endfunction

  logic [63:0] r, er;
  logic        c, o, z, ec, eo, ez;
  logic        seen;

  initial begin
    reset = 1'b1;
    for (int s = 0; s < 3; s++) begin
      in_valid[s] = 1'b0; out_ready[s] = 1'b1;
      opa[s] = '0; opb[s] = '0; opc[s] = '0;
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int s = 0; s < 3; s++) begin
      chk("reset in_ready",  64'(in_rdy[s]),  64'd1);
      chk("reset out_valid", 64'(out_vld[s]), 64'd0);
      chk("reset result",    res_o[s],        64'd0);
      chk("reset flags", {61'd0, cout_o[s], ovf_o[s], zero_o[s]}, 64'd0);
    end
    reset = 1'b0;

    // Directed cases, 32-bit / 8-bit chunks. Flags packed {c,o,z}.
    do_op(0, 64'd5, 64'd3, 5'b00000, 0, 0, r, c, o, z);
    chk("5+3 result", r, 64'd8);
    chk("5+3 flags", {61'd0, c, o, z}, {61'd0, 3'b000});

    do_op(0, 64'h7FFF_FFFF, 64'd1, 5'b00000, 0, 0, r, c, o, z);
    chk("max+1 result", r, 64'h8000_0000);
    chk("max+1 flags", {61'd0, c, o, z}, {61'd0, 3'b010});

    do_op(0, 64'h8000_0000, 64'd1, 5'b00001, 0, 0, r, c, o, z);
    chk("min-1 result", r, 64'h7FFF_FFFF);
    chk("min-1 flags", {61'd0, c, o, z}, {61'd0, 3'b110});

    do_op(0, 64'd5, 64'd5, 5'b11111, 0, 0, r, c, o, z);
    chk("5-5 result", r, 64'd0);
    chk("5-5 flags", {61'd0, c, o, z}, {61'd0, 3'b101});

    do_op(0, 64'hFFFF_FFFF, 64'd1, 5'b11110, 0, 0, r, c, o, z);
    chk("-1+1 result", r, 64'd0);
    chk("-1+1 flags", {61'd0, c, o, z}, {61'd0, 3'b101});

    // Backpressure: 10 cycles of out_ready low with in_valid poked.
    do_op(0, 64'h1234, 64'h0234, 5'b00001, 10, 1, r, c, o, z);
    chk("bp result", r, 64'h1000);
    chk("bp flags", {61'd0, c, o, z}, {61'd0, 3'b100});

    // Reset after two chunks of a RUN.
    @(negedge clk);
    in_valid[0] = 1'b1; opa[0] = 64'h89AB_CDEF; opb[0] = 64'h1357_9BDF; opc[0] = 5'b0;
    @(posedge clk);
    @(negedge clk);
    in_valid[0] = 1'b0;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    chk("mid-run out_valid", 64'(out_vld[0]), 64'd0);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    chk("post-reset in_ready",  64'(in_rdy[0]),  64'd1);
    chk("post-reset out_valid", 64'(out_vld[0]), 64'd0);
    chk("post-reset result",    res_o[0],        64'd0);
    chk("post-reset flags", {61'd0, cout_o[0], ovf_o[0], zero_o[0]}, 64'd0);
    seen = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (out_vld[0]) seen = 1'b1;
    end
    chk("no stale out_valid", 64'(seen), 64'd0);
    do_op(0, 64'd10, 64'd4, 5'b00001, 0, 0, r, c, o, z);
    chk("10-4 result", r, 64'd6);
    chk("10-4 flags", {61'd0, c, o, z}, {61'd0, 3'b100});

    // Randomized ops on the 8/1 and 64/64 instances.
    for (int s = 1; s < 3; s++) begin
      for (int k = 0; k < 200; k++) begin
        logic [63:0] a, b;
        logic [4:0]  op;
        int          hold;
        a    = rnd_opnd(wof(s));
        b    = rnd_opnd(wof(s));
        op   = 5'($urandom);
        hold = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 4) : 0;
        model(wof(s), a, b, op[0], er, ec, eo, ez);
        do_op(s, a, b, op, hold, 0, r, c, o, z);
        chk("rand result", r, er);
        chk("rand carry", 64'(c), 64'(ec));
        chk("rand overflow", 64'(o), 64'(eo));
        chk("rand zero", 64'(z), 64'(ez));
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/addsub_serial.md
Name: addsub_serial

Overview:
- Parametrised multi-cycle adder/subtracter: processes a WIDTH-bit operand pair CHUNK bits per cycle, LSB chunk first, with a ripple carry held in a register between cycles.
- Sits beside the single-cycle ALU add/sub path. Used where area matters more than latency, or where widths exceed 32 bits.
- Adds a valid/ready handshake plus carry-out and zero flags.

Parameters:
- WIDTH, 32: operand/result width in bits; must be a multiple of CHUNK.
- CHUNK, 8: bits processed per cycle; 1 <= CHUNK <= WIDTH.

Ports:
- clock  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- in_valid  in  1  request valid
- in_ready  out  1  block can accept a request
- data_operandA  in  WIDTH  operand A (two's complement)
- data_operandB  in  WIDTH  operand B (two's complement)
- ctrl_ALUopcode  in  5  bit0: 0 = A+B, 1 = A-B; bits[4:1] ignored
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts result
- data_result  out  WIDTH  sum/difference, modulo 2^WIDTH
- carry_out  out  1  carry out of the MSB (for subtraction, 1 = no borrow)
- overflow  out  1  signed overflow
- zero  out  1  data_result == 0

Behaviour:
- One clock domain (clock). Reset is synchronous and active-high.
- Reset values: state = IDLE, in_ready = 1, out_valid = 0, data_result = 0, carry_out = 0, overflow = 0, zero = 0. Internal chunk counter and carry register = 0.
- N = WIDTH/CHUNK. FSM states are IDLE, RUN and DONE.
- IDLE:
  - in_ready = 1.
  - On in_valid & in_ready: capture A; capture B' = bit0 ? ~B : B; carry = bit0; counter = 0; go to RUN.
- RUN:
  - in_ready = 0.
  - Each cycle: {c, s} = A[chunk i] + B'[chunk i] + carry.
  - Store s into result chunk i; carry <= c; counter++.
  - When the last chunk (i = N-1) completes:
    - carry_out <= c.
    - overflow <= (A[MSB] == B'[MSB]) & (s[MSB] != A[MSB]).
    - zero <= (full result == 0), evaluated on the final assembled value.
    - Go to DONE.
- DONE:
  - out_valid = 1; data_result and all flags stable.
  - When out_ready = 1, go to IDLE; out_valid drops next cycle.
  - While out_ready = 0, hold indefinitely with all outputs unchanged.
- Latency: request accepted at edge k; out_valid is first high in the cycle after edge k+N. In IDLE, out_valid = 0; the outputs retain the last result.
- Throughput: one op per N+2 cycles minimum. No overlap: in_ready = 0 in RUN and DONE, and in_valid is ignored there.
- Operands and opcode are sampled only at the accept edge. Later changes on data_operandA, data_operandB or ctrl_ALUopcode have no effect.
- Reset asserted in any state: the op is discarded and all reset values apply next cycle; no out_valid pulse.
- N = 1 (CHUNK = WIDTH): RUN lasts exactly one cycle. The behaviour is otherwise identical.
- Arithmetic is modulo 2^WIDTH. Overflow matches the carry-in(MSB) XOR carry-out(MSB) definition.
- Elaboration fails (generate-time check) if WIDTH % CHUNK != 0.

Test Plan:
- WIDTH=32, CHUNK=8: A=5, B=3, op=00000, out_ready=1 -> data_result=8, carry_out=0, overflow=0, zero=0; out_valid first high 5 cycles after the accept edge.
- WIDTH=32, CHUNK=8: A=0x7FFFFFFF, B=1, add -> 0x80000000, overflow=1, carry_out=0. Then A=0x80000000, B=1, op=00001 -> 0x7FFFFFFF, overflow=1, carry_out=1.
- WIDTH=32, CHUNK=8: A=5, B=5, sub -> 0, zero=1, carry_out=1, overflow=0. Then A=0xFFFFFFFF, B=1, add -> 0, zero=1, carry_out=1, overflow=0.
- Backpressure: out_ready=0 for 10 cycles after out_valid -> result/flags held, in_ready=0, a new in_valid is ignored. Then raise out_ready -> IDLE, in_ready=1 next cycle.
- Reset mid-RUN (2 chunks done) -> next cycle in_ready=1, out_valid=0, data_result=0. A following op A=10, B=4, sub -> 6 with normal latency.
- WIDTH=8, CHUNK=1 and WIDTH=64, CHUNK=64: 200 random add/sub ops checked against a reference model (result, carry_out, overflow, zero). Latency is 9 and 2 cycles respectively.
